mul_share_rr_arbiter: RTL and testbench



---
 rtl/mul_share_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mul_share_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_rr_arbiter
//
// Shares one pipelined unsigned x signed multiplier between NUM_REQ requesters.
// A round-robin arbiter accepts at most one operand pair per cycle. Each
// product is returned on a single response stream, tagged with the index of
// the requester that issued it. Responses leave in acceptance order.
//
// Pipeline: NUM_STAGE registered product stages feed the response register.
// Operands accepted at edge k are presented with rsp_valid=1 after edge
// k+NUM_STAGE when the pipeline advances every cycle. All stages shift only
// when the response register is empty or is being popped.
//
// Optional feature (macro MUL_SHARE_STATS_EN):
//   stat_grant_cnt : per-requester handshake counters, 32 bits each
//   stat_stall_cnt : cycles with rsp_valid && !rsp_ready
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester operand handshake
//   req_din0               packed unsigned operands, DIN0_WIDTH each
//   req_din1               packed signed operands, DIN1_WIDTH each
//   rsp_valid/rsp_ready    response handshake
//   rsp_dout               signed product resized to DOUT_WIDTH (LSBs kept)
//   rsp_id                 requester index for rsp_dout
// -----------------------------------------------------------------------------
module mul_share_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 3,
    parameter int DIN1_WIDTH = 7,
    parameter int DOUT_WIDTH = 10,
    parameter int NUM_STAGE  = 2,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic [ID_WIDTH-1:0]              rsp_id
`ifdef MUL_SHARE_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]            stat_grant_cnt,
    output logic [31:0]                      stat_stall_cnt
`endif
);

    logic                          adv_s;
    logic                          found_s;
    logic                          hs_s;
    logic [ID_WIDTH-1:0]           winner_s;
    int                            cand_s;
    logic [DIN0_WIDTH-1:0]         din0_sel_s;
    logic [DIN1_WIDTH-1:0]         din1_sel_s;
    logic signed [DOUT_WIDTH-1:0]  opa_s;
    logic signed [DOUT_WIDTH-1:0]  opb_s;
    logic signed [DOUT_WIDTH-1:0]  prod_s;

    logic [ID_WIDTH-1:0]           last_grant_r;
    logic                          stg_vld_r  [NUM_STAGE];
    logic [DOUT_WIDTH-1:0]         stg_dout_r [NUM_STAGE];
    logic [ID_WIDTH-1:0]           stg_id_r   [NUM_STAGE];

    // Whole pipeline moves only when the response slot is free or draining.
    assign adv_s = !rsp_valid || rsp_ready;
    assign hs_s  = found_s && adv_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = (int'(last_grant_r) + off) % NUM_REQ;
            if (!found_s && req_valid[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s[ID_WIDTH-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // One-hot ready for the winner, suppressed on stall and during reset.
    always_comb begin
        req_ready = '0;
        if (found_s && adv_s && aresetn) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux for the winner. Both operands are widened to the result
    // width first, so the multiply yields exactly the LSBs of the true product
    // (sign-extended when DOUT_WIDTH exceeds the full product width).
    always_comb begin
        din0_sel_s = req_din0[int'(winner_s)*DIN0_WIDTH +: DIN0_WIDTH];
        din1_sel_s = req_din1[int'(winner_s)*DIN1_WIDTH +: DIN1_WIDTH];
        opa_s      = DOUT_WIDTH'($signed({1'b0, din0_sel_s}));
        opb_s      = DOUT_WIDTH'($signed(din1_sel_s));
        prod_s     = opa_s * opb_s;
    end

    // Round-robin pointer moves only on an actual handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant_r <= ID_WIDTH'(NUM_REQ - 1);
        end else if (hs_s) begin
            last_grant_r <= winner_s;
        end
    end

    // Product pipeline plus response register; bubbles travel as invalid stages.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stg_vld_r[i]  <= 1'b0;
                stg_dout_r[i] <= '0;
                stg_id_r[i]   <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_dout  <= '0;
            rsp_id    <= '0;
        end else if (adv_s) begin
            stg_vld_r[0]  <= hs_s;
            stg_dout_r[0] <= prod_s;
            stg_id_r[0]   <= winner_s;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stg_vld_r[i]  <= stg_vld_r[i-1];
                stg_dout_r[i] <= stg_dout_r[i-1];
                stg_id_r[i]   <= stg_id_r[i-1];
            end
            rsp_valid <= stg_vld_r[NUM_STAGE-1];
            rsp_dout  <= stg_dout_r[NUM_STAGE-1];
            rsp_id    <= stg_id_r[NUM_STAGE-1];
        end
    end

`ifdef MUL_SHARE_STATS_EN
    logic [31:0] grant_cnt_r [NUM_REQ];
    logic [31:0] stall_cnt_r;

    // Free-running statistics; they observe the datapath and never feed it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_r[i] <= 32'd0;
            end
            stall_cnt_r <= 32'd0;
        end else begin
            if (hs_s) begin
                grant_cnt_r[winner_s] <= grant_cnt_r[winner_s] + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    // Pack the per-requester counters onto the output bus.
    always_comb begin
        stat_grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grant_cnt[i*32 +: 32] = grant_cnt_r[i];
        end
        stat_stall_cnt = stall_cnt_r;
    end
`endif

endmodule

// File: tb/tb_mul_share_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mul_share_rr_arbiter (default parameters).
// Reference model: round-robin winner computed arithmetically, in-flight
// products held in a queue with an age counter; an item is presented once it
// has aged NUM_STAGE advancing cycles. Define MUL_SHARE_STATS_EN to also
// check the statistics counters.
// -----------------------------------------------------------------------------
module tb_mul_share_rr_arbiter;

    localparam int N  = 4;
    localparam int W0 = 3;
    localparam int W1 = 7;
    localparam int WO = 10;
    localparam int NS = 2;
    localparam int WI = 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W0-1:0]   req_din0;
    logic [N*W1-1:0]   req_din1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WO-1:0]     rsp_dout;
    logic [WI-1:0]     rsp_id;
`ifdef MUL_SHARE_STATS_EN
    logic [N*32-1:0]   stat_grant_cnt;
    logic [31:0]       stat_stall_cnt;
`endif

    mul_share_rr_arbiter dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dout  (rsp_dout),
        .rsp_id    (rsp_id)
`ifdef MUL_SHARE_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          id;
        logic [9:0]  prod;
        int          age;
    } item_t;

    item_t       q[$];
    int          last_g;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          gcnt[N];
    int          stall_cnt;

    // stimulus state: a requester keeps valid and operands until its handshake
    logic        vld[N];
    logic [2:0]  opa[N];
    logic [6:0]  opb[N];
    logic        rdy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] ref_prod(input logic [2:0] x, input logic [6:0] y);
        int p;
        p = int'(x) * int'($signed(y));
        return p[9:0];
    endfunction

    task automatic model_reset();
        q.delete();
        last_g    = N - 1;
        stall_cnt = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    // Drive one cycle (called right after a falling edge), check, advance model.
    task automatic run_cycle();
        int          w;
        logic        exp_rv;
        logic        adv;
        logic [N-1:0] exp_rdy;
        item_t       it;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = vld[i];
            req_din0[i*W0 +: W0]  = opa[i];
            req_din1[i*W1 +: W1]  = opb[i];
        end
        rsp_ready = rdy;
        #1;
        exp_rv = (q.size() > 0) && (q[0].age == NS);
        adv    = !exp_rv || rdy;
        w      = -1;
        for (int off = 1; off <= N; off++) begin
            if (w < 0 && vld[(last_g + off) % N]) w = (last_g + off) % N;
        end
        exp_rdy = '0;
        if (adv && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("rsp_dout", 32'(rsp_dout), 32'(q[0].prod));
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        end
        if (exp_rv && !rdy) stall_cnt++;
        if (adv) begin
            if (exp_rv) void'(q.pop_front());
            foreach (q[j]) q[j].age++;
            if (w >= 0) begin
                it.id   = w;
                it.prod = ref_prod(opa[w], opb[w]);
                it.age  = 0;
                q.push_back(it);
                last_g  = w;
                gcnt[w]++;
                vld[w]  = 1'b0;
            end
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        rdy = 1'b1;
        for (int c = 0; c < n; c++) run_cycle();
    endtask

    // Single request on an empty pipeline with a fixed expected product.
    task automatic directed(input int id, input logic [2:0] x, input logic [6:0] y,
                            input logic [9:0] expv);
        int t;
        idle(NS + 2);
        vld[id] = 1'b1; opa[id] = x; opb[id] = y;
        t = 0;
        while (vld[id] && t < 10) begin run_cycle(); t++; end
        chk("hs_timeout", 32'(vld[id]), 32'd0);
        for (int c = 0; c < NS; c++) run_cycle();
        chk("dir_valid", 32'(rsp_valid), 32'd1);
        chk("dir_dout", 32'(rsp_dout), 32'(expv));
        chk("dir_id", 32'(rsp_id), 32'(id));
    endtask

`ifdef MUL_SHARE_STATS_EN
    task automatic chk_stats();
        for (int i = 0; i < N; i++) chk("stat_grant", stat_grant_cnt[i*32 +: 32], 32'(gcnt[i]));
        chk("stat_stall", stat_stall_cnt, 32'(stall_cnt));
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin vld[i] = 1'b0; opa[i] = '0; opb[i] = '0; end
        rdy       = 1'b1;
        aresetn   = 1'b0;
        req_valid = '1;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dout", 32'(rsp_dout), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
`ifdef MUL_SHARE_STATS_EN
        chk_stats();
`endif

        // directed arithmetic cases
        directed(0, 3'd5, 7'h7D, 10'h3F1);
        directed(0, 3'd7, 7'h40, 10'h240);
        directed(1, 3'd7, 7'h3F, 10'h1B9);
        directed(2, 3'd0, 7'h40, 10'h000);

        // all requesters held valid at full rate, then a 3-cycle stall
        idle(NS + 2);
        for (int c = 0; c < 17; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i]) begin
                    vld[i] = 1'b1; opa[i] = 3'($urandom); opb[i] = 7'($urandom);
                end
            end
            rdy = !(c >= 8 && c < 11);
            run_cycle();
        end

        // pointer after a grant to 3, then only 2 and 3 valid, then idle
        idle(NS + 2);
        vld[3] = 1'b1; opa[3] = 3'd1; opb[3] = 7'd1;
        run_cycle();
        vld[2] = 1'b1; opa[2] = 3'd2; opb[2] = 7'd3;
        vld[3] = 1'b1; opa[3] = 3'd4; opb[3] = 7'h7F;
        run_cycle();
        run_cycle();
        idle(3);
        vld[0] = 1'b1; vld[3] = 1'b1;
        run_cycle();
        run_cycle();

        // reset with products in flight
        idle(NS + 2);
        vld[0] = 1'b1; vld[1] = 1'b1; opa[0] = 3'd3; opb[0] = 7'd9; opa[1] = 3'd6; opb[1] = 7'd5;
        run_cycle();
        run_cycle();
        aresetn   = 1'b0;
        req_valid = '1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
`ifdef MUL_SHARE_STATS_EN
        chk_stats();
`endif
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        vld[1] = 1'b1; opa[1] = 3'd2; opb[1] = 7'h7E;
        run_cycle();
        for (int c = 0; c < NS + 3; c++) run_cycle();

        // randomized traffic with random back-pressure
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 0) begin
                    vld[i] = 1'b1;
                    opa[i] = 3'($urandom);
                    opb[i] = 7'($urandom);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        idle(NS + 3);
`ifdef MUL_SHARE_STATS_EN
        chk_stats();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
